// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared states and constants for the instruction memory loader
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } imem_state_t;

  localparam int MEM_BYTES_DEFAULT = 256;
  localparam logic [3:0] WR_ALL = 4'b1111;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - big-endian byte-to-word assembly with running XOR checksum
module imem_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        idx_clear,
  input  logic        shift,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  checksum
);

  logic [1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= 2'd0;
      word     <= 32'h0;
      checksum <= 8'h00;
    end else if (clear) begin
      idx      <= 2'd0;
      checksum <= 8'h00;
    end else if (idx_clear) begin
      idx <= 2'd0;
    end else if (shift) begin
      idx      <= idx + 2'd1;
      checksum <= checksum ^ byte_data;
      // First byte of a word lands in the most significant lane
      case (idx)
        2'd0:    word[31:24] <= byte_data;
        2'd1:    word[23:16] <= byte_data;
        2'd2:    word[15:8]  <= byte_data;
        default: word[7:0]   <= byte_data;
      endcase
    end
  end

  assign word_ready = shift && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing big-endian words into the instruction store
module imem_loader
  import imem_pkg::*;
#(
  parameter int          MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [3:0]  mem_byte_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        cpu_stall,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  words_loaded
);

  localparam logic [8:0] WORD_CAP = 9'(MEM_BYTES / 4);

  imem_state_t state, next_state;
  logic [7:0]  len;
  logic        xfer;
  logic        pk_clear, pk_idx_clear, pk_shift, len_load;
  logic        word_ready;
  logic [31:0] word;
  logic [7:0]  checksum;

  assign xfer = rx_valid && rx_ready;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .idx_clear  (pk_idx_clear),
    .shift      (pk_shift),
    .byte_data  (rx_data),
    .word       (word),
    .word_ready (word_ready),
    .checksum   (checksum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      len          <= 8'd0;
      words_loaded <= 8'd0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && start) begin
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= 8'd0;
      end
      if (len_load) len <= rx_data;
      if (state == ST_WRITE) words_loaded <= words_loaded + 8'd1;
      if (next_state == ST_DONE && state != ST_DONE) done <= 1'b1;
      if (next_state == ST_ERR && state != ST_ERR) err <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    rx_ready     = 1'b0;
    mem_byte_wr  = 4'b0000;
    pk_clear     = 1'b0;
    pk_idx_clear = 1'b0;
    pk_shift     = 1'b0;
    len_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          pk_clear   = 1'b1;
          next_state = ST_LEN;
        end
      end
      ST_LEN: begin
        rx_ready = 1'b1;
        if (xfer) begin
          if (rx_data == 8'd0) begin
            next_state = ST_CHK;
          end else if ({1'b0, rx_data} > WORD_CAP) begin
            next_state = ST_ERR;
          end else begin
            len_load     = 1'b1;
            pk_idx_clear = 1'b1;
            next_state   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        rx_ready = 1'b1;
        pk_shift = xfer;
        if (word_ready) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        mem_byte_wr = WR_ALL;
        next_state  = (words_loaded + 8'd1 == len) ? ST_CHK : ST_DATA;
      end
      ST_CHK: begin
        rx_ready = 1'b1;
        if (xfer) next_state = (rx_data == checksum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: next_state = ST_IDLE;
      ST_ERR:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Stall and busy cover exactly the frame-receiving states
  assign busy      = (state == ST_LEN) || (state == ST_DATA) ||
                     (state == ST_WRITE) || (state == ST_CHK);
  assign cpu_stall = busy;
  assign mem_addr  = BASE_ADDR + {22'd0, words_loaded, 2'b00};
  assign mem_data  = word;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [3:0]  mem_byte_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        cpu_stall;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  words_loaded;

  imem_loader #(.MEM_BYTES(256), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_byte_wr  (mem_byte_wr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .cpu_stall    (cpu_stall),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done, exp_err;
  logic [7:0]  exp_words;
  logic [7:0]  model_csum;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  // Frame-level model: the writes and final flags follow directly from the frame bytes
  function automatic void plan_frame();
    int n;
    logic [7:0] x;
    n = int'(frame[0]);
    x = 8'h00;
    exp_addr.delete();
    exp_data.delete();
    if (n > 64) begin
      exp_done  = 1'b0;
      exp_err   = 1'b1;
      exp_words = 8'd0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(32'(4 * i));
        exp_data.push_back({frame[4*i+1], frame[4*i+2], frame[4*i+3], frame[4*i+4]});
      end
      for (int j = 1; j <= 4 * n; j++) x = x ^ frame[j];
      model_csum = x;
      exp_done   = (frame[4*n+1] == x);
      exp_err    = !exp_done;
      exp_words  = 8'(n);
    end
  endfunction

  // Cycle-level observer: a write is due exactly one cycle after each word-completing byte
  initial begin : compare
    int k;
    logic [7:0] obs_len;
    logic exp_wr;
    k = 0;
    obs_len = 8'd0;
    exp_wr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k = 0;
        exp_wr = 1'b0;
      end else begin
        chk("wr_strobe", 32'(mem_byte_wr), exp_wr ? 32'hF : 32'h0);
        if (mem_byte_wr != 4'b0000) begin
          chk("ready_in_write", 32'(rx_ready), 32'h0);
          if (exp_addr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h want none", mem_addr, mem_data);
          end else begin
            chk("wr_addr", mem_addr, exp_addr.pop_front());
            chk("wr_data", mem_data, exp_data.pop_front());
          end
        end
        chk("stall_eq_busy", 32'(cpu_stall), 32'(busy));
        if (!busy) chk("idle_ready", 32'(rx_ready), 32'h0);
        exp_wr = 1'b0;
        if (!busy && start) k = 0;
        if (rx_valid && rx_ready) begin
          if (k == 0) obs_len = rx_data;
          else if (obs_len <= 8'd64 && k <= 4 * int'(obs_len) && (k % 4) == 0) exp_wr = 1'b1;
          k++;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_frame(input int mode, input int mid_idx, input int limit);
    int i;
    int budget;
    logic mid_done;
    i = 0;
    budget = 0;
    mid_done = 1'b0;
    while (i < frame.size() && i < limit) begin
      rx_data = frame[i];
      case (mode)
        0:       rx_valid = 1'b1;
        1:       rx_valid = ~rx_valid;
        default: rx_valid = ($urandom_range(0, 2) != 0);
      endcase
      if (i == mid_idx && !mid_done) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      @(negedge clk);
      if (rx_valid && rx_ready) i++;
      @(posedge clk); #1;
      start = 1'b0;
      budget++;
      if (budget > 5000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drive_timeout: got %0d bytes accepted want %0d", i, frame.size());
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic finish_session(input string tag);
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
    chk({tag, "_pending"}, 32'(exp_addr.size()), 32'h0);
  endtask

  task automatic run_frame(input string tag, input int mode, input int mid_idx);
    plan_frame();
    pulse_start();
    chk({tag, "_busy_on"}, 32'(busy), 32'h1);
    chk({tag, "_stall_on"}, 32'(cpu_stall), 32'h1);
    drive_frame(mode, mid_idx, 100000);
    finish_session(tag);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int r;
    logic [7:0] b, x;

    rst_n = 1'b0;
    rx_valid = 1'b1;
    rx_data = 8'hAA;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_wr", 32'(mem_byte_wr), 32'h0);
    end
    chk("rst_ready", 32'(rx_ready), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_words", 32'(words_loaded), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rx_valid = 1'b0;

    frame = '{8'd2, 8'h00, 8'h24, 8'h68, 8'h20, 8'h01, 8'h47, 8'h68, 8'h20, 8'h62};
    plan_frame();
    chk("model_w0", exp_data[0], 32'h00246820);
    chk("model_w1", exp_data[1], 32'h01476820);
    chk("model_csum", 32'(model_csum), 32'h62);
    chk("model_done", 32'(exp_done), 32'h1);
    run_frame("nominal", 0, -1);
    run_frame("backpressure", 1, -1);
    run_frame("midstart", 2, 3);

    frame = '{8'd1, 8'h08, 8'h00, 8'h00, 8'h18, 8'hFF};
    plan_frame();
    chk("model_bad_err", 32'(exp_err), 32'h1);
    run_frame("badsum", 0, -1);

    frame = '{8'd65};
    run_frame("oversize", 0, -1);

    frame = '{8'd0, 8'h00};
    run_frame("len0", 0, -1);

    for (int f = 0; f < 24; f++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       n = $urandom_range(0, 8);
      else if (r == 7) n = 64;
      else if (r == 8) n = 65;
      else             n = $urandom_range(66, 255);
      frame.delete();
      frame.push_back(8'(n));
      if (n <= 64) begin
        x = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          b = 8'($urandom);
          frame.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(0, 3) != 0) frame.push_back(x);
        else frame.push_back(x ^ 8'($urandom_range(1, 255)));
      end
      run_frame("random", 2, ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : -1);
    end

    frame.delete();
    frame.push_back(8'd3);
    for (int j = 0; j < 12; j++) frame.push_back(8'($urandom));
    frame.push_back(8'h00);
    plan_frame();
    pulse_start();
    drive_frame(0, -1, 6);
    chk("rst_mid_left", 32'(exp_addr.size()), 32'h2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_addr.delete();
    exp_data.delete();
    for (int c = 0; c < 20; c++) @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_done", 32'(done), 32'h0);
    chk("rst_mid_err", 32'(err), 32'h0);
    chk("rst_mid_words", 32'(words_loaded), 32'h0);
    rx_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
